clock_divider_bank: RTL and testbench

Parametrised multi-channel successor to the single fixed-ratio clock divider. It produces CHANNELS independent divided clocks and one-cycle tick strobes from one input clock. Each channel's divisor is programmable at run time and changes glitch-free at a terminal count. The bank feeds the display row-scan, PWM and UART-baud timing from one place.

---
 rtl/clock_divider_bank_pkg.sv | 14 +
 rtl/clock_divider_channel.sv | 103 ++++++++++
 rtl/clock_divider_bank.sv | 49 ++++
 tb/tb_clock_divider_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_bank_pkg.sv
// Shared definitions for the divider bank: default sizing, the divisor value
// that means "channel disabled", and the channel-index width helper.
package clock_divider_bank_pkg;

   localparam int DEF_DIV_WIDTH   = 16;
   localparam int DEF_DEFAULT_DIV = 5;
   localparam int DIV_DISABLED    = 0;

   // Width of a channel index; a single-channel bank still gets a 1-bit index.
   function automatic int chan_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: terminal counter, pending divisor register and the
// registered clk_out / tick outputs. Divisor changes only take effect at
// cnt=0 boundaries (terminal, restart or sync), so the counter can never sit
// above the active divisor.
module clock_divider_channel
   import clock_divider_bank_pkg::*;
#(
   parameter int DIV_WIDTH   = DEF_DIV_WIDTH,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 wr_restart,
   input  logic [DIV_WIDTH-1:0] wr_data,
   input  logic                 sync,
   output logic                 clk_out,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
   logic [DIV_WIDTH-1:0] div_active, div_active_nxt;
   logic [DIV_WIDTH-1:0] div_pending, div_pending_nxt;
   logic                 pending_valid, pending_valid_nxt;
   logic                 clk_out_r, clk_out_nxt;
   logic                 tick_r, tick_nxt;
   logic                 disabled;
   logic                 terminal;

   assign disabled = (div_active == DIV_WIDTH'(DIV_DISABLED));
   assign terminal = !disabled && (cnt == div_active - DIV_WIDTH'(1));

   // Next-state: sync beats restart beats terminal/count; a resulting divisor
   // of zero forces the channel quiet in the same edge.
   always_comb begin
      cnt_nxt           = cnt;
      div_active_nxt    = div_active;
      div_pending_nxt   = div_pending;
      pending_valid_nxt = pending_valid;
      clk_out_nxt       = clk_out_r;
      tick_nxt          = 1'b0;
      if (sync) begin
         cnt_nxt     = '0;
         clk_out_nxt = 1'b0;
         if (pending_valid) div_active_nxt = div_pending;
         pending_valid_nxt = 1'b0;
         if (wr_en) div_active_nxt = wr_data;
      end else if (wr_en && wr_restart) begin
         div_active_nxt    = wr_data;
         cnt_nxt           = '0;
         clk_out_nxt       = 1'b0;
         pending_valid_nxt = 1'b0;
      end else if (disabled) begin
         cnt_nxt     = '0;
         clk_out_nxt = 1'b0;
         if (wr_en) div_active_nxt = wr_data;
      end else if (terminal) begin
         cnt_nxt     = '0;
         tick_nxt    = 1'b1;
         clk_out_nxt = ~clk_out_r;
         if (wr_en) begin
            div_active_nxt = wr_data;
         end else if (pending_valid) begin
            div_active_nxt = div_pending;
         end
         pending_valid_nxt = 1'b0;
      end else begin
         cnt_nxt = cnt + DIV_WIDTH'(1);
         if (wr_en) begin
            div_pending_nxt   = wr_data;
            pending_valid_nxt = 1'b1;
         end
      end
      if (div_active_nxt == DIV_WIDTH'(DIV_DISABLED)) begin
         cnt_nxt     = '0;
         clk_out_nxt = 1'b0;
         tick_nxt    = 1'b0;
      end
   end

   // Channel state register with asynchronous clear to the default divisor.
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         div_active    <= DIV_WIDTH'(DEFAULT_DIV);
         div_pending   <= '0;
         pending_valid <= 1'b0;
         clk_out_r     <= 1'b0;
         tick_r        <= 1'b0;
      end else begin
         cnt           <= cnt_nxt;
         div_active    <= div_active_nxt;
         div_pending   <= div_pending_nxt;
         pending_valid <= pending_valid_nxt;
         clk_out_r     <= clk_out_nxt;
         tick_r        <= tick_nxt;
      end
   end

   assign clk_out = clk_out_r;
   assign tick    = tick_r;

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one input clock.
// wr_chan is decoded into per-channel write enables; indices with no channel
// simply match nothing and are dropped.
module clock_divider_bank
   import clock_divider_bank_pkg::*;
#(
   parameter  int CHANNELS    = 4,
   parameter  int DIV_WIDTH   = DEF_DIV_WIDTH,
   parameter  int DEFAULT_DIV = DEF_DEFAULT_DIV,
   localparam int CHAN_W      = chan_width(CHANNELS)
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [CHAN_W-1:0]    wr_chan,
   input  logic [DIV_WIDTH-1:0] wr_data,
   input  logic                 wr_restart,
   input  logic                 sync,
   output logic [CHANNELS-1:0]  clk_out,
   output logic [CHANNELS-1:0]  tick
);

   logic [CHANNELS-1:0] chan_wr_en;

   // Write-enable decode: at most one channel selected per cycle.
   always_comb begin
      chan_wr_en = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         chan_wr_en[k] = wr_en && (wr_chan == CHAN_W'(k));
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      clock_divider_channel #(
         .DIV_WIDTH   (DIV_WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
         .clk_in     (clk_in),
         .reset      (reset),
         .wr_en      (chan_wr_en[k]),
         .wr_restart (wr_restart),
         .wr_data    (wr_data),
         .sync       (sync),
         .clk_out    (clk_out[k]),
         .tick       (tick[k])
      );
   end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: directed scenarios followed by random traffic,
// compared against a timeline model (edges remaining to the next terminal and
// half-period parity per channel).
module tb_clock_divider_bank;

   localparam int CH   = 4;
   localparam int DW   = 16;
   localparam int DDIV = 5;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [1:0]    wr_chan;
   logic [DW-1:0] wr_data;
   logic          wr_restart;
   logic          sync;
   logic [CH-1:0] clk_out;
   logic [CH-1:0] tick;

   int errors = 0;
   int checks = 0;
   int ecount = 0;

   // Reference model state
   int m_div  [CH];
   int m_pend [CH];   // -1 = no pending divisor
   int m_rem  [CH];   // edges until next terminal count
   bit m_half [CH];   // clk_out level = parity of completed half periods
   bit m_tick [CH];

   clock_divider_bank #(
      .CHANNELS    (CH),
      .DIV_WIDTH   (DW),
      .DEFAULT_DIV (DDIV)
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_chan    (wr_chan),
      .wr_data    (wr_data),
      .wr_restart (wr_restart),
      .sync       (sync),
      .clk_out    (clk_out),
      .tick       (tick)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, ecount, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_div[c] = DDIV; m_pend[c] = -1; m_rem[c] = DDIV;
         m_half[c] = 0;   m_tick[c] = 0;
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         model_reset();
         return;
      end
      for (int c = 0; c < CH; c++) begin
         bit hit;
         int wd;
         hit = wr_en && (int'(wr_chan) == c);
         wd  = int'(wr_data);
         if (sync) begin
            if (m_pend[c] >= 0) m_div[c] = m_pend[c];
            m_pend[c] = -1;
            if (hit) m_div[c] = wd;
            m_rem[c] = m_div[c]; m_half[c] = 0; m_tick[c] = 0;
         end else if (hit && wr_restart) begin
            m_div[c] = wd; m_pend[c] = -1;
            m_rem[c] = m_div[c]; m_half[c] = 0; m_tick[c] = 0;
         end else if (m_div[c] == 0) begin
            if (hit) m_div[c] = wd;
            m_rem[c] = m_div[c]; m_half[c] = 0; m_tick[c] = 0;
         end else begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin
               m_tick[c] = 1;
               m_half[c] = ~m_half[c];
               if (hit) m_div[c] = wd;
               else if (m_pend[c] >= 0) m_div[c] = m_pend[c];
               m_pend[c] = -1;
               m_rem[c] = m_div[c];
            end else begin
               m_tick[c] = 0;
               if (hit) m_pend[c] = wd;
            end
         end
         if (m_div[c] == 0) begin
            m_half[c] = 0; m_tick[c] = 0;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [CH-1:0] e_clk, e_tick;
      for (int c = 0; c < CH; c++) begin
         e_clk[c]  = m_half[c];
         e_tick[c] = m_tick[c];
      end
      chk({tag, "_clk"}, clk_out, e_clk);
      chk({tag, "_tick"}, tick, e_tick);
   endtask

   // One clock: drive inputs, let the edge sample them, check at the falling edge.
   task automatic step(input bit we, input int ch, input int d, input bit rs, input bit sy,
                       input string tag);
      wr_en = we; wr_chan = 2'(ch); wr_data = DW'(d); wr_restart = rs; sync = sy;
      @(posedge clk_in);
      model_edge();
      ecount++;
      @(negedge clk_in);
      wr_en = 0; wr_restart = 0; sync = 0;
      check_model(tag);
   endtask

   initial begin
      reset = 1; wr_en = 0; wr_chan = 0; wr_data = 0; wr_restart = 0; sync = 0;
      model_reset();
      @(posedge clk_in); @(posedge clk_in);
      @(negedge clk_in);
      chk("reset_clk", clk_out, 4'h0);
      chk("reset_tick", tick, 4'h0);
      reset = 0;

      // Default divisor from reset release
      for (int i = 1; i <= 27; i++) begin
         step(0, 0, 0, 0, 0, "default");
         if (i == 4)  chk("pre_first_tick", tick, 4'h0);
         if (i == 5)  begin chk("first_tick", tick, 4'hF); chk("first_rise", clk_out, 4'hF); end
         if (i == 10) chk("first_fall", clk_out, 4'h0);
         if (i == 15 || i == 25) chk("tick_period", tick, 4'hF);
      end

      // Plain write at cnt=2: current half period completes, then N=3
      step(1, 1, 3, 0, 0, "glitch_wr");
      for (int i = 0; i < 12; i++) begin
         step(0, 0, 0, 0, 0, "glitch");
         if (ecount == 30) chk("old_half_done", tick & 4'h2, 4'h2);
         if (ecount == 33) chk("new_half_3", tick & 4'h2, 4'h2);
      end

      // Restart write mid-count
      step(1, 2, 2, 1, 0, "restart_wr");
      chk("restart_low", clk_out & 4'h4, 4'h0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, "restart");

      // Disable channel 3, then re-enable with N=1
      step(1, 3, 0, 0, 0, "disable_wr");
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, "disabled");
      chk("disabled_quiet", (clk_out | tick) & 4'h8, 4'h0);
      step(1, 3, 1, 0, 0, "enable_wr");
      step(0, 0, 0, 0, 0, "enable");
      chk("n1_tick", tick & 4'h8, 4'h8);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, "n1");

      // Write landing exactly on a terminal edge of channel 0
      for (int i = 0; i < 20 && m_rem[0] != 1; i++) step(0, 0, 0, 0, 0, "to_term");
      step(1, 0, 4, 0, 0, "term_wr");
      chk("term_wr_tick", tick & 4'h1, 4'h1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, "term_after");

      // Sync together with a write to channel 2
      step(1, 2, 3, 0, 1, "sync_wr");
      chk("sync_clk", clk_out, 4'h0);
      chk("sync_tick", tick, 4'h0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, "sync_after");

      // Asynchronous reset between edges
      #2 reset = 1;
      #1;
      chk("async_clk", clk_out, 4'h0);
      chk("async_tick", tick, 4'h0);
      step(0, 0, 0, 0, 0, "in_reset");
      reset = 0;
      for (int i = 1; i <= 12; i++) begin
         step(0, 0, 0, 0, 0, "post_reset");
         if (i == 5) chk("post_reset_tick", tick, 4'hF);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 4) == 0, int'($urandom_range(0, CH - 1)),
              int'($urandom_range(0, 6)), ($urandom % 3) == 0,
              ($urandom % 25) == 0, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
